// File: rtl/contador_arbitro_if.sv
// Bundle between the requester/counter side and the arbiter: request/grant handshake
// plus the contador16 ENB/MODO/D/Q/RCO wiring.
interface contador_arbitro_if #(
    parameter int WIDTH = 16
);
    logic             REQ0;
    logic [WIDTH-1:0] VAL0;
    logic             REQ1;
    logic [WIDTH-1:0] VAL1;
    logic             GNT0;
    logic             GNT1;
    logic             DONE0;
    logic             DONE1;
    logic             BUSY;
    logic             ERR;
    logic             ENB;
    logic [1:0]       MODO;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             RCO;

    modport slave (
        input  REQ0, VAL0, REQ1, VAL1, Q, RCO,
        output GNT0, GNT1, DONE0, DONE1, BUSY, ERR, ENB, MODO, D
    );

    modport master (
        output REQ0, VAL0, REQ1, VAL1, Q, RCO,
        input  GNT0, GNT1, DONE0, DONE1, BUSY, ERR, ENB, MODO, D
    );
endinterface

// File: rtl/contador_arbitro.sv
// Round-robin owner of a shared contador16 used as a one-shot down-counting timer:
// load the owner's value, count to zero, pulse DONE for that owner.
module contador_arbitro #(
    parameter int         WIDTH     = 16,
    parameter logic [1:0] MODO_LOAD = 2'b11,
    parameter logic [1:0] MODO_DOWN = 2'b01
) (
    input  logic               CLK,
    input  logic               RESET,
    contador_arbitro_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LOAD, COUNT, FIN} state_t;

    state_t state_q, state_d;
    logic   owner_q, owner_d;
    logic   last_owner_q, last_owner_d;
    logic   err_q, err_d;

    logic   owner_req;
    logic   q_zero;

    assign owner_req = owner_q ? bus.REQ1 : bus.REQ0;
    assign q_zero    = (bus.Q == '0);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        err_d        = err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.REQ0 && bus.REQ1) begin
                    owner_d = ~last_owner_q;
                    state_d = LOAD;
                end else if (bus.REQ0) begin
                    owner_d = 1'b0;
                    state_d = LOAD;
                end else if (bus.REQ1) begin
                    owner_d = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (!owner_req) begin
                    last_owner_d = owner_q;
                    state_d      = IDLE;
                end else begin
                    state_d = COUNT;
                end
            end
            COUNT: begin
                // Overflow from the counter while still nonzero means it is out of step.
                if (bus.RCO && !q_zero) err_d = 1'b1;
                if (!owner_req) begin
                    last_owner_d = owner_q;
                    state_d      = IDLE;
                end else if (q_zero) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                last_owner_d = owner_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.GNT0  = (state_q != IDLE) && !owner_q;
        bus.GNT1  = (state_q != IDLE) &&  owner_q;
        bus.DONE0 = (state_q == FIN)  && !owner_q;
        bus.DONE1 = (state_q == FIN)  &&  owner_q;
        bus.BUSY  = (state_q != IDLE);
        bus.ERR   = err_q;
        bus.ENB   = 1'b0;
        bus.MODO  = 2'b00;
        bus.D     = '0;
        if (state_q != IDLE) bus.D = owner_q ? bus.VAL1 : bus.VAL0;
        if (state_q == LOAD) begin
            bus.ENB  = 1'b1;
            bus.MODO = MODO_LOAD;
        end else if (state_q == COUNT && !q_zero) begin
            bus.ENB  = 1'b1;
            bus.MODO = MODO_DOWN;
        end
    end
endmodule

// File: tb/tb_contador_arbitro.sv
// Bench for contador_arbitro: behavioural contador16 stand-in plus a transaction-level
// timing model (grant at N, DONE at N+V+2, round-robin on ties).
module tb_contador_arbitro;
    logic        clk;
    logic        rst;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic        m_last;
    logic [15:0] cnt_q = '0;

    contador_arbitro_if #(.WIDTH(16)) bus ();

    contador_arbitro #(
        .WIDTH(16),
        .MODO_LOAD(2'b11),
        .MODO_DOWN(2'b01)
    ) dut (
        .CLK(clk),
        .RESET(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // contador16 behaviour: 11 = load D, 01 = count down
    always @(posedge clk) begin
        if (bus.ENB) begin
            if (bus.MODO == 2'b11) cnt_q <= bus.D;
            else if (bus.MODO == 2'b01) cnt_q <= cnt_q - 16'd1;
        end
    end
    assign bus.Q = cnt_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt0"}, 32'(bus.GNT0), 32'd0);
        check({tag, "_gnt1"}, 32'(bus.GNT1), 32'd0);
        check({tag, "_done0"}, 32'(bus.DONE0), 32'd0);
        check({tag, "_done1"}, 32'(bus.DONE1), 32'd0);
        check({tag, "_busy"}, 32'(bus.BUSY), 32'd0);
        check({tag, "_err"}, 32'(bus.ERR), 32'd0);
        check({tag, "_enb"}, 32'(bus.ENB), 32'd0);
        check({tag, "_modo"}, 32'(bus.MODO), 32'd0);
        check({tag, "_d"}, 32'(bus.D), 32'd0);
    endtask

    // One arbitration round: both requesters raise REQ together, each holds until its DONE.
    task automatic run_round(input logic r0, input logic r1,
                             input logic [15:0] v0, input logic [15:0] v1);
        int   n, d1, d2, first, second, vf, vs;
        logic in1, in2;
        first  = (r0 && r1) ? ((m_last == 1'b1) ? 0 : 1) : (r0 ? 0 : 1);
        second = (r0 && r1) ? 1 - first : -1;
        vf     = int'(first == 1 ? v1 : v0);
        vs     = int'(first == 1 ? v0 : v1);
        bus.REQ0 = r0; bus.VAL0 = v0;
        bus.REQ1 = r1; bus.VAL1 = v1;
        n  = cyc + 1;
        d1 = n + vf + 2;
        d2 = (second >= 0) ? d1 + 2 + vs + 2 : d1;
        while (cyc < d2 + 1) begin
            @(negedge clk);
            in1 = (cyc >= n) && (cyc <= d1);
            in2 = (second >= 0) && (cyc >= d1 + 2) && (cyc <= d2);
            check("rr_gnt0", 32'(bus.GNT0), 32'((in1 && first == 0) || (in2 && second == 0)));
            check("rr_gnt1", 32'(bus.GNT1), 32'((in1 && first == 1) || (in2 && second == 1)));
            check("rr_busy", 32'(bus.BUSY), 32'(in1 || in2));
            check("rr_done0", 32'(bus.DONE0),
                  32'((cyc == d1 && first == 0) || (cyc == d2 && second == 0)));
            check("rr_done1", 32'(bus.DONE1),
                  32'((cyc == d1 && first == 1) || (cyc == d2 && second == 1)));
            if (cyc == n || (second >= 0 && cyc == d1 + 2)) begin
                check("rr_load_enb", 32'(bus.ENB), 32'd1);
                check("rr_load_modo", 32'(bus.MODO), 32'd3);
                check("rr_load_d", 32'(bus.D), 32'(cyc == n ? vf : vs));
            end
            if (cyc == d1) begin
                if (first == 0) bus.REQ0 = 1'b0; else bus.REQ1 = 1'b0;
            end
            if (second >= 0 && cyc == d2) begin
                if (second == 0) bus.REQ0 = 1'b0; else bus.REQ1 = 1'b0;
            end
        end
        m_last = (second >= 0) ? second[0] : first[0];
    endtask

    initial begin
        int   a;
        logic seen;
        rst = 1'b1;
        bus.REQ0 = 1'b0; bus.VAL0 = '0;
        bus.REQ1 = 1'b0; bus.VAL1 = '0;
        bus.RCO  = 1'b0;
        m_last   = 1'b1;

        // reset held two cycles
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_busy", 32'(bus.BUSY), 32'd0);
        @(negedge clk);
        check("post_reset_busy2", 32'(bus.BUSY), 32'd0);

        // single request, then ties alternating, then zero value
        run_round(1'b1, 1'b0, 16'd5, 16'd0);
        run_round(1'b1, 1'b1, 16'd3, 16'd2);
        run_round(1'b1, 1'b1, 16'd3, 16'd2);
        run_round(1'b0, 1'b1, 16'd0, 16'd0);

        // abort: drop REQ0 mid-count while REQ1 waits
        bus.REQ0 = 1'b1; bus.VAL0 = 16'd100;
        @(negedge clk);
        bus.REQ1 = 1'b1; bus.VAL1 = 16'd4;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (bus.Q == 16'd60) seen = 1'b1;
            check("abort_no_done0", 32'(bus.DONE0), 32'd0);
        end
        check("abort_reach_q60", 32'(seen), 32'd1);
        check("abort_gnt0_before", 32'(bus.GNT0), 32'd1);
        bus.REQ0 = 1'b0;
        a = cyc;
        @(negedge clk);
        check("abort_idle_busy", 32'(bus.BUSY), 32'd0);
        check("abort_idle_enb", 32'(bus.ENB), 32'd0);
        check("abort_idle_gnt0", 32'(bus.GNT0), 32'd0);
        check("abort_idle_done0", 32'(bus.DONE0), 32'd0);
        @(negedge clk);
        check("abort_next_gnt1", 32'(bus.GNT1), 32'd1);
        check("abort_next_d", 32'(bus.D), 32'd4);
        while (cyc < a + 8) begin
            @(negedge clk);
            check("abort_done1", 32'(bus.DONE1), 32'(cyc == a + 8));
            check("abort_done0_quiet", 32'(bus.DONE0), 32'd0);
        end
        bus.REQ1 = 1'b0;
        m_last = 1'b1;
        @(negedge clk);

        // reset in the middle of a countdown
        bus.REQ0 = 1'b1; bus.VAL0 = 16'd100;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (bus.Q == 16'd40 && bus.GNT0) seen = 1'b1;
        end
        check("midreset_reach_q40", 32'(seen), 32'd1);
        rst = 1'b1;
        bus.REQ0 = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        rst = 1'b0;
        m_last = 1'b1;
        @(negedge clk);
        check("midreset_release_busy", 32'(bus.BUSY), 32'd0);

        // sticky ERR from RCO with nonzero Q
        bus.REQ1 = 1'b1; bus.VAL1 = 16'd20;
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            if (bus.Q == 16'd7 && bus.GNT1) seen = 1'b1;
        end
        check("err_reach_q7", 32'(seen), 32'd1);
        check("err_clear_before", 32'(bus.ERR), 32'd0);
        bus.RCO = 1'b1;
        @(negedge clk);
        bus.RCO = 1'b0;
        check("err_set", 32'(bus.ERR), 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            if (bus.DONE1) seen = 1'b1;
        end
        check("err_flow_done1", 32'(seen), 32'd1);
        bus.REQ1 = 1'b0;
        @(negedge clk);
        check("err_sticky", 32'(bus.ERR), 32'd1);
        check("err_idle_busy", 32'(bus.BUSY), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("err_cleared_by_reset", 32'(bus.ERR), 32'd0);
        rst = 1'b0;
        m_last = 1'b1;
        @(negedge clk);

        // randomized rounds against the timing model
        for (int r = 0; r < 12; r++) begin
            logic        rr0, rr1;
            logic [15:0] rv0, rv1;
            rr0 = 1'($urandom_range(0, 1));
            rr1 = 1'($urandom_range(0, 1));
            if (!rr0 && !rr1) rr0 = 1'b1;
            rv0 = 16'($urandom_range(0, 12));
            rv1 = 16'($urandom_range(0, 12));
            run_round(rr0, rr1, rv0, rv1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
